dcache_2way: RTL and testbench

Two-way set-associative, write-back, write-allocate data cache between the CPU load/store path and the block-wide data memory. Replaces the direct-mapped data cache with parametrised geometry, per-set LRU replacement and a fully synchronous controller. It uses the same CPU-side Read/Write/Busy_Wait protocol and the same memory-side Mem_Read/Mem_Write/Mem_BusyWait protocol, so it drops into the existing CPU/memory hookup.

---
 rtl/dcache_2way.sv | 177 +++++++++++++++++
 tb/tb_dcache_2way.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_2way.sv
// Two-way set-associative, write-back, write-allocate data cache with per-set LRU replacement.
// Optional hit/miss counters are enabled by defining DCACHE_PERF_CNT_EN.
module dcache_2way #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned WORD_W   = 8,
    parameter int unsigned OFFSET_W = 2,
    parameter int unsigned INDEX_W  = 2
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Read,
    input  logic                         Write,
    input  logic [ADDR_W-1:0]            Address,
    input  logic [WORD_W-1:0]            Write_Data,
    output logic [WORD_W-1:0]            Read_Data,
    output logic                         Busy_Wait,
    output logic                         Mem_Read,
    output logic                         Mem_Write,
    output logic [ADDR_W-OFFSET_W-1:0]   Mem_Address,
    output logic [(WORD_W<<OFFSET_W)-1:0] Mem_WriteData,
    input  logic [(WORD_W<<OFFSET_W)-1:0] Mem_ReadData,
    input  logic                         Mem_BusyWait
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [15:0]                  Hit_Count,
    output logic [15:0]                  Miss_Count
`endif
);

    localparam int unsigned TAG_W   = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned BLOCK_W = WORD_W << OFFSET_W;
    localparam int unsigned SETS    = 1 << INDEX_W;
    localparam int unsigned WORDS   = 1 << OFFSET_W;

    typedef enum logic [1:0] {StIdle, StWriteBack, StMemRead, StUpdate} state_t;

    state_t                   state_q;
    logic [1:0][SETS-1:0]     valid_q;
    logic [1:0][SETS-1:0]     dirty_q;
    logic [SETS-1:0]          lru_q;
    logic [TAG_W-1:0]         tag_q  [2][SETS];
    logic [BLOCK_W-1:0]       data_q [2][SETS];
    logic [BLOCK_W-1:0]       fill_q;
    logic                     victim_q;
    logic                     mem_read_q;
    logic                     mem_write_q;

    logic [TAG_W-1:0]         addr_tag;
    logic [INDEX_W-1:0]       addr_index;
    logic [OFFSET_W-1:0]      addr_offset;
    logic                     req;
    logic                     hit_way0;
    logic                     hit_way1;
    logic                     hit;
    logic                     hit_way;
    logic                     victim;
    logic                     victim_dirty;
    logic [BLOCK_W-1:0]       hit_block;
    logic [BLOCK_W-1:0]       wr_block;
    logic [WORD_W-1:0]        hit_word;

    assign addr_tag    = Address[ADDR_W-1 -: TAG_W];
    assign addr_index  = Address[OFFSET_W +: INDEX_W];
    assign addr_offset = Address[OFFSET_W-1:0];
    assign req         = Read | Write;

    assign hit_way0 = valid_q[0][addr_index] && (tag_q[0][addr_index] == addr_tag);
    assign hit_way1 = valid_q[1][addr_index] && (tag_q[1][addr_index] == addr_tag);
    assign hit      = hit_way0 | hit_way1;
    assign hit_way  = hit_way1;
    assign hit_block = data_q[hit_way][addr_index];

    // Invalid ways are filled first (way 0 preferred) before LRU is consulted.
    assign victim = !valid_q[0][addr_index] ? 1'b0 :
                    !valid_q[1][addr_index] ? 1'b1 : lru_q[addr_index];
    assign victim_dirty = valid_q[victim][addr_index] && dirty_q[victim][addr_index];

    always_comb begin
        hit_word = '0;
        wr_block = hit_block;
        for (int k = 0; k < WORDS; k++) begin
            if (addr_offset == OFFSET_W'(k)) begin
                hit_word = hit_block[k*WORD_W +: WORD_W];
                wr_block[k*WORD_W +: WORD_W] = Write_Data;
            end
        end
    end

    assign Read_Data     = (state_q == StIdle && hit) ? hit_word : '0;
    assign Busy_Wait     = req && !(state_q == StIdle && hit);
    assign Mem_Read      = mem_read_q;
    assign Mem_Write     = mem_write_q;
    assign Mem_Address   = (state_q == StWriteBack) ? {tag_q[victim_q][addr_index], addr_index}
                                                    : {addr_tag, addr_index};
    assign Mem_WriteData = data_q[victim_q][addr_index];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= StIdle;
            valid_q     <= '0;
            dirty_q     <= '0;
            lru_q       <= '0;
            victim_q    <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req) begin
                        if (hit) begin
                            lru_q[addr_index] <= ~hit_way;
                            if (Write) begin
                                data_q[hit_way][addr_index]  <= wr_block;
                                dirty_q[hit_way][addr_index] <= 1'b1;
                            end
                        end else begin
                            victim_q <= victim;
                            if (victim_dirty) begin
                                state_q     <= StWriteBack;
                                mem_write_q <= 1'b1;
                            end else begin
                                state_q    <= StMemRead;
                                mem_read_q <= 1'b1;
                            end
                        end
                    end
                end
                StWriteBack: begin
                    if (!Mem_BusyWait) begin
                        state_q     <= StMemRead;
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b1;
                    end
                end
                StMemRead: begin
                    if (!Mem_BusyWait) begin
                        fill_q     <= Mem_ReadData;
                        state_q    <= StUpdate;
                        mem_read_q <= 1'b0;
                    end
                end
                StUpdate: begin
                    // LRU is left alone; the hit that follows the fill updates it.
                    data_q[victim_q][addr_index]  <= fill_q;
                    tag_q[victim_q][addr_index]   <= addr_tag;
                    valid_q[victim_q][addr_index] <= 1'b1;
                    dirty_q[victim_q][addr_index] <= 1'b0;
                    state_q                       <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == StIdle && req) begin
            if (hit && hit_cnt_q != 16'hFFFF) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (!hit && miss_cnt_q != 16'hFFFF) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign Hit_Count  = hit_cnt_q;
    assign Miss_Count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_2way.sv
// Directed self-checking bench for dcache_2way with a 5-busy-cycle block memory model.
`timescale 1ns/1ps
module tb_dcache_2way;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Read = 1'b0;
    logic        Write = 1'b0;
    logic [7:0]  Address = 8'h00;
    logic [7:0]  Write_Data = 8'h00;
    logic [7:0]  Read_Data;
    logic        Busy_Wait;
    logic        Mem_Read;
    logic        Mem_Write;
    logic [5:0]  Mem_Address;
    logic [31:0] Mem_WriteData;
    logic [31:0] Mem_ReadData;
    logic        Mem_BusyWait;
`ifdef DCACHE_PERF_CNT_EN
    logic [15:0] Hit_Count;
    logic [15:0] Miss_Count;
`endif

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [64];
    int          busy_cnt = 0;

    int          stalls;
    logic        saw_rd;
    logic        saw_wr;
    logic        wb_done;
    logic        rd_early;
    logic [5:0]  rd_addr;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  rdata;

    dcache_2way dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Read         (Read),
        .Write        (Write),
        .Address      (Address),
        .Write_Data   (Write_Data),
        .Read_Data    (Read_Data),
        .Busy_Wait    (Busy_Wait),
        .Mem_Read     (Mem_Read),
        .Mem_Write    (Mem_Write),
        .Mem_Address  (Mem_Address),
        .Mem_WriteData(Mem_WriteData),
        .Mem_ReadData (Mem_ReadData),
        .Mem_BusyWait (Mem_BusyWait)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .Hit_Count    (Hit_Count),
        .Miss_Count   (Miss_Count)
`endif
    );

    always #5 Clk = ~Clk;

    // Memory stays busy for 5 cycles of each request, then completes.
    assign Mem_BusyWait = (Mem_Read | Mem_Write) && (busy_cnt < 5);
    assign Mem_ReadData = mem[Mem_Address];

    always @(posedge Clk) begin
        if (!(Mem_Read | Mem_Write) || !Mem_BusyWait) busy_cnt <= 0;
        else busy_cnt <= busy_cnt + 1;
    end

    task automatic do_reset();
        Reset = 1'b1;
        Read  = 1'b0;
        Write = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
    endtask

    task automatic access(input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
        @(posedge Clk);
        #1;
        Read = !wr; Write = wr; Address = addr; Write_Data = wdata;
        stalls = 0; saw_rd = 0; saw_wr = 0; wb_done = 0; rd_early = 0;
        rd_addr = '0; wr_addr = '0; wr_data = '0; rdata = 'x;
        forever begin
            @(negedge Clk);
            if (Mem_Read) begin
                saw_rd = 1; rd_addr = Mem_Address;
                if (!wb_done) rd_early = 1;
            end
            if (Mem_Write) begin
                if (!saw_wr) begin wr_addr = Mem_Address; wr_data = Mem_WriteData; end
                saw_wr = 1;
                if (!Mem_BusyWait) wb_done = 1;
            end
            if (!Busy_Wait) begin rdata = Read_Data; break; end
            stalls++;
            if (stalls > 100) begin
                tests++; fails++;
                $display("FAIL access_timeout addr=%h: Busy_Wait still high after %0d cycles", addr, stalls);
                break;
            end
        end
        @(posedge Clk);
        #1 Read = 1'b0; Write = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge Clk);
        tests++; if (Busy_Wait !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", Busy_Wait); end
        tests++; if (Mem_Read !== 1'b0) begin fails++; $display("FAIL reset_mem_read: got %b want 0", Mem_Read); end
        tests++; if (Mem_Write !== 1'b0) begin fails++; $display("FAIL reset_mem_write: got %b want 0", Mem_Write); end
        tests++; if (Read_Data !== 8'h00) begin fails++; $display("FAIL reset_read_data: got %h want 00", Read_Data); end
    endtask

    task automatic test_cold_miss();
        do_reset();
        access(1'b0, 8'h25, 8'h00);
        tests++; if (!(saw_rd && rd_addr === 6'h09)) begin fails++; $display("FAIL cold_mem_addr: got rd=%b addr=%h want rd=1 addr=09", saw_rd, rd_addr); end
        tests++; if (rdata !== 8'hBB) begin fails++; $display("FAIL cold_data: got %h want bb", rdata); end
        tests++; if (stalls != 8) begin fails++; $display("FAIL cold_latency: got %0d want 8", stalls); end
        tests++; if (saw_wr !== 1'b0) begin fails++; $display("FAIL cold_no_wb: got %b want 0", saw_wr); end
        access(1'b0, 8'h25, 8'h00);
        tests++; if (stalls != 0 || saw_rd) begin fails++; $display("FAIL cold_rehit: got stalls=%0d rd=%b want 0/0", stalls, saw_rd); end
        tests++; if (rdata !== 8'hBB) begin fails++; $display("FAIL cold_rehit_data: got %h want bb", rdata); end
    endtask

    task automatic test_two_tags();
        do_reset();
        access(1'b0, 8'h05, 8'h00);
        tests++; if (rdata !== 8'h81 || rd_addr !== 6'h01 || saw_wr) begin fails++; $display("FAIL two_fill_a: got %h/%h/%b want 81/01/0", rdata, rd_addr, saw_wr); end
        access(1'b0, 8'h45, 8'h00);
        tests++; if (rdata !== 8'h91 || rd_addr !== 6'h11 || saw_wr) begin fails++; $display("FAIL two_fill_b: got %h/%h/%b want 91/11/0", rdata, rd_addr, saw_wr); end
        access(1'b0, 8'h05, 8'h00);
        tests++; if (stalls != 0 || rdata !== 8'h81) begin fails++; $display("FAIL two_hit_a: got %0d/%h want 0/81", stalls, rdata); end
        access(1'b0, 8'h45, 8'h00);
        tests++; if (stalls != 0 || rdata !== 8'h91) begin fails++; $display("FAIL two_hit_b: got %0d/%h want 0/91", stalls, rdata); end
    endtask

    // Continues from test_two_tags: 0x05 in way 0, 0x45 in way 1.
    task automatic test_lru_evict();
        access(1'b0, 8'h05, 8'h00);
        tests++; if (stalls != 0) begin fails++; $display("FAIL lru_touch: got %0d stalls want 0", stalls); end
        access(1'b0, 8'h85, 8'h00);
        tests++; if (rdata !== 8'hA1 || stalls != 8 || saw_wr) begin fails++; $display("FAIL lru_fill: got %h/%0d/%b want a1/8/0", rdata, stalls, saw_wr); end
        access(1'b0, 8'h05, 8'h00);
        tests++; if (stalls != 0 || rdata !== 8'h81) begin fails++; $display("FAIL lru_keep: got %0d/%h want 0/81", stalls, rdata); end
        access(1'b0, 8'h45, 8'h00);
        tests++; if (!saw_rd || stalls != 8 || rdata !== 8'h91) begin fails++; $display("FAIL lru_evicted: got rd=%b %0d/%h want 1 8/91", saw_rd, stalls, rdata); end
    endtask

    task automatic test_dirty_wb();
        do_reset();
        access(1'b0, 8'h46, 8'h00);
        access(1'b1, 8'h46, 8'h5A);
        tests++; if (stalls != 0 || saw_wr) begin fails++; $display("FAIL wr_hit: got %0d/%b want 0/0", stalls, saw_wr); end
        access(1'b0, 8'h46, 8'h00);
        tests++; if (stalls != 0 || rdata !== 8'h5A) begin fails++; $display("FAIL wr_readback: got %0d/%h want 0/5a", stalls, rdata); end
        access(1'b0, 8'h45, 8'h00);
        tests++; if (stalls != 0 || rdata !== 8'h91) begin fails++; $display("FAIL wr_neighbour: got %0d/%h want 0/91", stalls, rdata); end
        access(1'b0, 8'h06, 8'h00);
        tests++; if (rdata !== 8'h81 || saw_wr) begin fails++; $display("FAIL wb_second_fill: got %h/%b want 81/0", rdata, saw_wr); end
        access(1'b0, 8'h86, 8'h00);
        tests++; if (!saw_wr || wr_addr !== 6'h11) begin fails++; $display("FAIL wb_addr: got wr=%b addr=%h want 1/11", saw_wr, wr_addr); end
        tests++; if (wr_data !== 32'h915A9191) begin fails++; $display("FAIL wb_data: got %h want 915a9191", wr_data); end
        tests++; if (rd_early || !saw_rd || rd_addr !== 6'h21) begin fails++; $display("FAIL wb_then_read: got early=%b rd=%b addr=%h want 0/1/21", rd_early, saw_rd, rd_addr); end
        tests++; if (rdata !== 8'hA1 || stalls != 14) begin fails++; $display("FAIL wb_result: got %h/%0d want a1/14", rdata, stalls); end
    endtask

    task automatic test_reset_mid_miss();
        int n;
        do_reset();
        access(1'b0, 8'h25, 8'h00);
        @(posedge Clk);
        #1 Read = 1'b1; Address = 8'h85;
        n = 0;
        do begin @(negedge Clk); n++; end while (!Mem_Read && n < 20);
        tests++; if (Mem_Read !== 1'b1) begin fails++; $display("FAIL mid_start: got Mem_Read=%b want 1", Mem_Read); end
        @(negedge Clk);
        Reset = 1'b1; Read = 1'b0;
        @(negedge Clk);
        tests++; if (Mem_Read !== 1'b0 || Mem_Write !== 1'b0) begin fails++; $display("FAIL mid_reset_mem: got %b/%b want 0/0", Mem_Read, Mem_Write); end
        tests++; if (Busy_Wait !== 1'b0 || Read_Data !== 8'h00) begin fails++; $display("FAIL mid_reset_out: got %b/%h want 0/00", Busy_Wait, Read_Data); end
        @(posedge Clk);
        #1 Reset = 1'b0;
        access(1'b0, 8'h25, 8'h00);
        tests++; if (!saw_rd || stalls != 8 || rdata !== 8'hBB) begin fails++; $display("FAIL mid_reread: got rd=%b %0d/%h want 1 8/bb", saw_rd, stalls, rdata); end
    endtask

`ifdef DCACHE_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        tests++; if (Hit_Count !== 16'd0 || Miss_Count !== 16'd0) begin fails++; $display("FAIL perf_reset: got %0d/%0d want 0/0", Hit_Count, Miss_Count); end
        access(1'b0, 8'h25, 8'h00);
        access(1'b0, 8'h25, 8'h00);
        tests++; if (Hit_Count !== 16'd2) begin fails++; $display("FAIL perf_hits: got %0d want 2", Hit_Count); end
        tests++; if (Miss_Count !== 16'd1) begin fails++; $display("FAIL perf_misses: got %0d want 1", Miss_Count); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = {4{8'h80 | 8'(i)}};
        mem[9] = 32'hDDCCBBAA;
        test_reset();
        test_cold_miss();
        test_two_tags();
        test_lru_evict();
        test_dirty_wb();
        test_reset_mid_miss();
`ifdef DCACHE_PERF_CNT_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
